ha_serial_add_ctrl: RTL and testbench

Bit-serial adder controller that time-shares the team's half-adder cell to perform WIDTH-bit additions, one bit per clock, LSB first. Two half-adder instances plus an OR gate form the per-bit full-adder slice. The block owns the carry flop, operand shift registers, bit counter and the FSM that sequences them. It sits between an upstream operand producer and a downstream result consumer, with valid/ready handshakes on both sides.

---
 rtl/ha_serial_add_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ha_serial_add_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder built from two time-shared half-adder cells, LSB first.
// Optional subtract mode (op_sub port) is enabled by defining HA_SERIAL_SUB_EN.

module ha_serial_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module ha_serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef HA_SERIAL_SUB_EN
  input  logic             op_sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_shift_s;
  logic [WIDTH-1:0]   b_load_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;
  logic               carry_init_s;
  logic               s1_s;
  logic               c1_s;
  logic               s_s;
  logic               c2_s;
  logic               carry_s;
  logic               accept_s;
  logic               last_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

`ifdef HA_SERIAL_SUB_EN
  // Subtraction is A + ~B + 1: invert B at load and seed the carry.
  assign b_load_s     = op_sub ? ~op_b : op_b;
  assign carry_init_s = op_sub;
`else
  assign b_load_s     = op_b;
  assign carry_init_s = 1'b0;
`endif

  ha_serial_half_adder u_h1 (.a(a_r[0]), .b(b_r[0]),  .s(s1_s), .c(c1_s));
  ha_serial_half_adder u_h2 (.a(s1_s),   .b(carry_r), .s(s_s),  .c(c2_s));
  assign carry_s = c1_s | c2_s;

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift_s = s_s;
    end else begin : g_res_wn
      assign res_shift_s = {s_s, res_r[WIDTH-1:1]};
    end
  endgenerate

  assign accept_s = (state_r == IDLE) && in_valid;
  assign last_s   = (state_r == RUN) && (cnt_r == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand shifters, carry, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      carry_r     <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        a_r     <= op_a;
        b_r     <= b_load_s;
        res_r   <= {WIDTH{1'b0}};
        cnt_r   <= {CNT_W{1'b0}};
        carry_r <= carry_init_s;
      end else if (state_r == RUN) begin
        a_r     <= a_r >> 1;
        b_r     <= b_r >> 1;
        res_r   <= res_shift_s;
        cnt_r   <= cnt_r + CNT_W'(1);
        carry_r <= carry_s;
      end
      // sum/cout only update on entry to DONE so partial results never leak.
      if (last_s) begin
        sum_r  <= res_shift_s;
        cout_r <= carry_s;
      end
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Directed self-checking bench for ha_serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
// Subtract-mode steps are compiled in when HA_SERIAL_SUB_EN is defined.

module tb_ha_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, cout, busy;
  logic [7:0] op_a, op_b, sum;
  logic       d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_cout, d1_busy;
  logic [0:0] d1_op_a, d1_op_b, d1_sum;
`ifdef HA_SERIAL_SUB_EN
  logic       op_sub, d1_op_sub;
`endif
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  ha_serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef HA_SERIAL_SUB_EN
    .op_sub(op_sub),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  ha_serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef HA_SERIAL_SUB_EN
    .op_sub(d1_op_sub),
`endif
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .op_a(d1_op_a), .op_b(d1_op_b),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .sum(d1_sum), .cout(d1_cout),
    .busy(d1_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accept edge until out_valid rises (bounded).
  task automatic wait_valid(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      step;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
  endtask

  // Accepts one operand pair and leaves the DUT in DONE.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_sum, input logic exp_cout);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    step;
    in_valid = 1'b0;
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    wait_valid(tag, 8);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  initial begin
    bit seen_valid;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; op_a = 8'h00; op_b = 8'h00;
    d1_in_valid = 1'b0; d1_out_ready = 1'b1; d1_op_a = 1'b0; d1_op_b = 1'b0;
`ifdef HA_SERIAL_SUB_EN
    op_sub = 1'b0; d1_op_sub = 1'b0;
`endif
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'h00);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step;

    // 0x5A + 0x33 with consumer always ready
    do_op("add5a33", 8'h5A, 8'h33, 8'h8D, 1'b0);
    step;
    check("add5a33_out_valid_clr", 32'(out_valid), 32'd0);
    check("add5a33_in_ready_back", 32'(in_ready), 32'd1);

    // Back-to-back: in_valid held high, second pair presented during RUN
    op_a = 8'hFF; op_b = 8'h01; in_valid = 1'b1;
    step;
    op_a = 8'hFF; op_b = 8'hFF;
    wait_valid("b2b_first", 8);
    check("b2b_first_sum", 32'(sum), 32'h00);
    check("b2b_first_cout", 32'(cout), 32'd1);
    step;
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    check("b2b_idle_out_valid", 32'(out_valid), 32'd0);
    step;
    check("b2b_second_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_valid("b2b_second", 8);
    check("b2b_second_sum", 32'(sum), 32'hFE);
    check("b2b_second_cout", 32'(cout), 32'd1);
    step;

    // Backpressure: hold DONE for 5 cycles with a new request pending
    out_ready = 1'b0;
    do_op("bp", 8'h12, 8'h34, 8'h46, 1'b0);
    op_a = 8'h01; op_b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h46);
      check("bp_hold_cout", 32'(cout), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    step;
    check("bp_pending_accepted", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_valid("bp_pending", 8);
    check("bp_pending_sum", 32'(sum), 32'h02);
    step;

    // Asynchronous reset three cycles into RUN
    op_a = 8'h0F; op_b = 8'h0F; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step; step; step;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sum", 32'(sum), 32'h00);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (out_valid) seen_valid = 1'b1;
    end
    check("rst_mid_no_out_valid", 32'(seen_valid), 32'd0);
    do_op("post_rst", 8'h01, 8'h01, 8'h02, 1'b0);
    step;

    // WIDTH=1 instance: 1+1
    d1_op_a = 1'b1; d1_op_b = 1'b1; d1_in_valid = 1'b1;
    step;
    d1_in_valid = 1'b0;
    check("w1_busy", 32'(d1_busy), 32'd1);
    check("w1_not_yet_valid", 32'(d1_out_valid), 32'd0);
    step;
    check("w1_out_valid", 32'(d1_out_valid), 32'd1);
    check("w1_sum", 32'(d1_sum), 32'd0);
    check("w1_cout", 32'(d1_cout), 32'd1);
    step;
    check("w1_back_idle", 32'(d1_in_ready), 32'd1);

`ifdef HA_SERIAL_SUB_EN
    op_sub = 1'b1;
    do_op("sub10m01", 8'h10, 8'h01, 8'h0F, 1'b1);
    step;
    do_op("sub00m01", 8'h00, 8'h01, 8'hFF, 1'b0);
    step;
    op_sub = 1'b0;
    do_op("sub_off_add", 8'h5A, 8'h33, 8'h8D, 1'b0);
    step;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
